// File: rtl/aes_mix_pkg.sv
// rtl/aes_mix_pkg.sv - shared types and GF(2^8) helpers for the MixColumns engine
package aes_mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mix_fsm_t;

    typedef logic [7:0][3:0] aes_col_t;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    function automatic logic [7:0] gm09(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ b;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(b) ^ b;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ b;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ gm2(b);
    endfunction

    // Column 0 occupies the most significant 32 bits of the state.
    function automatic aes_col_t col_of(input logic [127:0] state, input logic [1:0] idx);
        aes_col_t col;
        case (idx)
            2'd0:    col = state[127:96];
            2'd1:    col = state[95:64];
            2'd2:    col = state[63:32];
            default: col = state[31:0];
        endcase
        return col;
    endfunction

endpackage

// File: rtl/mix_invmix_col.sv
// rtl/mix_invmix_col.sv - selects one state column and applies MixColumns or InvMixColumns
module mix_invmix_col
    import aes_mix_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [1:0]   i_col_sel,
    input  logic         i_enc_dec,
    output logic [31:0]  o_col
);

    logic [31:0] w_col;
    logic [7:0]  w_b0;
    logic [7:0]  w_b1;
    logic [7:0]  w_b2;
    logic [7:0]  w_b3;

    assign w_col = col_of(i_state, i_col_sel);
    assign w_b0  = w_col[31:24];
    assign w_b1  = w_col[23:16];
    assign w_b2  = w_col[15:8];
    assign w_b3  = w_col[7:0];

    always_comb begin
        o_col = '0;
        if (i_enc_dec) begin
            o_col[31:24] = gm2(w_b0) ^ gm3(w_b1) ^ w_b2 ^ w_b3;
            o_col[23:16] = w_b0 ^ gm2(w_b1) ^ gm3(w_b2) ^ w_b3;
            o_col[15:8]  = w_b0 ^ w_b1 ^ gm2(w_b2) ^ gm3(w_b3);
            o_col[7:0]   = gm3(w_b0) ^ w_b1 ^ w_b2 ^ gm2(w_b3);
        end else begin
            o_col[31:24] = gm14(w_b0) ^ gm11(w_b1) ^ gm13(w_b2) ^ gm09(w_b3);
            o_col[23:16] = gm09(w_b0) ^ gm14(w_b1) ^ gm11(w_b2) ^ gm13(w_b3);
            o_col[15:8]  = gm13(w_b0) ^ gm09(w_b1) ^ gm14(w_b2) ^ gm11(w_b3);
            o_col[7:0]   = gm11(w_b0) ^ gm13(w_b1) ^ gm09(w_b2) ^ gm14(w_b3);
        end
    end

endmodule

// File: rtl/mix_cols_seq_engine.sv
// rtl/mix_cols_seq_engine.sv - sequential in-place MixColumns/InvMixColumns over a 128-bit state
module mix_cols_seq_engine
    import aes_mix_pkg::*;
#(
    parameter int NUM_COLS = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_state,
    input  logic         i_enc_dec,
    input  logic         i_bypass,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_state,
    output logic         o_busy
);

    localparam int BEATS = 4 / NUM_COLS;
    localparam int SHIFT = (NUM_COLS == 4) ? 2 : (NUM_COLS == 2) ? 1 : 0;

    if (!(NUM_COLS == 1 || NUM_COLS == 2 || NUM_COLS == 4)) begin : g_bad_num_cols
        $error("mix_cols_seq_engine: NUM_COLS must be 1, 2 or 4");
    end

    mix_fsm_t     r_state;
    logic [1:0]   r_cnt;
    logic [127:0] r_work;
    logic         r_enc;
    logic         r_byp;
    logic         r_valid;

    logic [1:0]   w_sel   [NUM_COLS];
    logic [31:0]  w_mixed [NUM_COLS];
    logic [127:0] w_work_next;
    logic         w_last;
    logic         w_mix_en;

    // Lane g of beat cnt works on column cnt*NUM_COLS + g.
    for (genvar g = 0; g < NUM_COLS; g++) begin : g_col
        assign w_sel[g] = (r_cnt << SHIFT) | 2'(g);

        mix_invmix_col u_col (
            .i_state   (r_work),
            .i_col_sel (w_sel[g]),
            .i_enc_dec (r_enc),
            .o_col     (w_mixed[g])
        );
    end

    always_comb begin
        w_work_next = r_work;
        for (int g = 0; g < NUM_COLS; g++) begin
            for (int c = 0; c < 4; c++) begin
                if (w_sel[g] == 2'(c)) begin
                    w_work_next[127-32*c -: 32] = w_mixed[g];
                end
            end
        end
    end

    assign w_last   = (r_cnt == 2'(BEATS - 1));
    assign w_mix_en = (r_state == ST_RUN) && !r_byp;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_work  <= '0;
            r_enc   <= 1'b0;
            r_byp   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_work <= i_state;
                        r_enc  <= i_enc_dec;
                        r_byp  <= i_bypass;
                        r_cnt  <= 2'd0;
                        if (i_bypass) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_mix_en) begin
                        r_work <= w_work_next;
                    end
                    if (w_last) begin
                        r_cnt   <= 2'd0;
                        r_state <= ST_DONE;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = (r_state == ST_IDLE);
    assign o_busy  = (r_state != ST_IDLE);
    assign o_valid = r_valid;
    assign o_state = r_work;

endmodule

// File: tb/tb_mix_cols_seq_engine.sv
// tb/tb_mix_cols_seq_engine.sv - directed and scoreboard checks for NUM_COLS 1, 2 and 4
module tb_mix_cols_seq_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] st_in;
    logic         enc_in;
    logic         byp_in;
    logic         v     [3];
    logic         rdy   [3];
    logic         ov    [3];
    logic         ordy  [3];
    logic         obusy [3];
    logic [127:0] ost   [3];

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [127:0] PT_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] CT_A = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] PT_B = 128'hd4d4d4d5_01010101_c6c6c6c6_db135345;
    localparam logic [127:0] CT_B = 128'hd5d5d7d6_01010101_c6c6c6c6_8e4da1bc;
    localparam logic [127:0] BYP  = 128'h00112233_44556677_8899aabb_ccddeeff;

    always #5 clk = ~clk;

    mix_cols_seq_engine #(.NUM_COLS(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(v[0]), .o_ready(ordy[0]), .i_state(st_in),
        .i_enc_dec(enc_in), .i_bypass(byp_in), .o_valid(ov[0]), .i_ready(rdy[0]),
        .o_state(ost[0]), .o_busy(obusy[0])
    );
    mix_cols_seq_engine #(.NUM_COLS(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(v[1]), .o_ready(ordy[1]), .i_state(st_in),
        .i_enc_dec(enc_in), .i_bypass(byp_in), .o_valid(ov[1]), .i_ready(rdy[1]),
        .o_state(ost[1]), .o_busy(obusy[1])
    );
    mix_cols_seq_engine #(.NUM_COLS(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(v[2]), .o_ready(ordy[2]), .i_state(st_in),
        .i_enc_dec(enc_in), .i_bypass(byp_in), .o_valid(ov[2]), .i_ready(rdy[2]),
        .o_state(ost[2]), .o_busy(obusy[2])
    );

    // Reference: generic shift-and-add GF multiply over a circulant matrix.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic enc);
        logic [7:0]   row0 [4];
        logic [127:0] r = '0;
        logic [7:0]   acc;
        if (enc) begin
            row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01;
        end else begin
            row0[0] = 8'h0e; row0[1] = 8'h0b; row0[2] = 8'h0d; row0[3] = 8'h09;
        end
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gf_mul(row0[(k - rw + 4) % 4], s[127-32*c-8*k -: 8]);
                end
                r[127-32*c-8*rw -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic do_txn(input int d, input logic [127:0] st, input logic enc, input logic byp,
                          input logic [127:0] exp, input int exp_n, input string tag);
        int n;
        @(negedge clk);
        n_checks++;
        if (ordy[d] !== 1'b1) $display("FAIL %s idle_ready: got %b want 1", tag, ordy[d]);
        else n_pass++;
        st_in = st; enc_in = enc; byp_in = byp; v[d] = 1'b1; rdy[d] = 1'b1;
        @(negedge clk);
        v[d] = 1'b0;
        n = 0;
        while (ov[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n !== exp_n) $display("FAIL %s latency: got %0d edges want %0d", tag, n, exp_n);
        else n_pass++;
        n_checks++;
        if (ost[d] !== exp) $display("FAIL %s state: got %h want %h", tag, ost[d], exp);
        else n_pass++;
        n_checks++;
        if (obusy[d] !== 1'b1) $display("FAIL %s busy_in_done: got %b want 1", tag, obusy[d]);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ov[d] !== 1'b0 || ordy[d] !== 1'b1)
            $display("FAIL %s release: got valid=%b ready=%b want 0/1", tag, ov[d], ordy[d]);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; st_in = '0; enc_in = 1'b0; byp_in = 1'b0;
        for (int d = 0; d < 3; d++) begin v[d] = 1'b0; rdy[d] = 1'b0; end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (ov[d] !== 1'b0 || ost[d] !== 128'h0 || ordy[d] !== 1'b1 || obusy[d] !== 1'b0)
                $display("FAIL reset_state[%0d]: got v=%b st=%h rdy=%b busy=%b want 0/0/1/0",
                         d, ov[d], ost[d], ordy[d], obusy[d]);
            else n_pass++;
        end
    endtask

    task automatic test_enc_nc1();
        do_txn(0, PT_A, 1'b1, 1'b0, CT_A, 4, "enc_nc1");
    endtask

    task automatic test_dec_nc4_nc2();
        do_txn(2, CT_A, 1'b0, 1'b0, PT_A, 1, "dec_nc4");
        do_txn(1, CT_A, 1'b0, 1'b0, PT_A, 2, "dec_nc2");
        do_txn(1, PT_B, 1'b1, 1'b0, CT_B, 2, "enc_nc2");
    endtask

    task automatic test_bypass();
        do_txn(0, BYP, 1'b1, 1'b1, BYP, 0, "bypass_nc1");
        do_txn(2, BYP, 1'b0, 1'b1, BYP, 0, "bypass_nc4");
        do_txn(0, PT_B, 1'b1, 1'b0, CT_B, 4, "enc_d4col");
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        st_in = PT_A; enc_in = 1'b1; byp_in = 1'b0; v[0] = 1'b1; rdy[0] = 1'b0;
        @(negedge clk);
        v[0] = 1'b0;
        n = 0;
        while (ov[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (ov[0] !== 1'b1) $display("FAIL bp_valid_timeout: got %b want 1", ov[0]);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            st_in  = {$urandom, $urandom, $urandom, $urandom};
            enc_in = ~enc_in;
            byp_in = 1'b1;
            v[0]   = 1'b1;
            @(negedge clk);
            n_checks++;
            if (ov[0] !== 1'b1 || ost[0] !== CT_A || ordy[0] !== 1'b0)
                $display("FAIL bp_hold[%0d]: got v=%b st=%h rdy=%b want 1/%h/0",
                         i, ov[0], ost[0], ordy[0], CT_A);
            else n_pass++;
        end
        v[0] = 1'b0; byp_in = 1'b0; rdy[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ov[0] !== 1'b0 || ordy[0] !== 1'b1 || ost[0] !== CT_A)
            $display("FAIL bp_release: got v=%b rdy=%b st=%h want 0/1/%h", ov[0], ordy[0], ost[0], CT_A);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        st_in = PT_A; enc_in = 1'b1; byp_in = 1'b0; v[0] = 1'b1; rdy[0] = 1'b1;
        @(negedge clk);
        v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (obusy[0] !== 1'b1 || ov[0] !== 1'b0)
            $display("FAIL midrun_busy: got busy=%b v=%b want 1/0", obusy[0], ov[0]);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (ov[0] !== 1'b0 || ost[0] !== 128'h0 || ordy[0] !== 1'b1 || obusy[0] !== 1'b0)
            $display("FAIL midrun_reset: got v=%b st=%h rdy=%b busy=%b want 0/0/1/0",
                     ov[0], ost[0], ordy[0], obusy[0]);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        do_txn(0, PT_A, 1'b1, 1'b0, CT_A, 4, "after_reset");
    endtask

    task automatic test_back_to_back(input int d);
        logic [127:0] exp_q [$];
        logic [127:0] cur;
        logic [127:0] want;
        logic         cur_enc;
        logic         cur_byp;
        int           sent = 0;
        int           got  = 0;
        int           cyc  = 0;
        cur     = {$urandom, $urandom, $urandom, $urandom};
        cur_enc = 1'($urandom_range(0, 1));
        cur_byp = ($urandom_range(0, 3) == 0);
        while (got < 8 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (sent < 8) begin
                v[d] = 1'($urandom_range(0, 1));
                st_in = cur; enc_in = cur_enc; byp_in = cur_byp;
            end else begin
                v[d] = 1'b0;
            end
            rdy[d] = 1'($urandom_range(0, 1));
            if (ov[d] === 1'b1 && rdy[d] === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b[%0d] duplicate: got %h want no output", d, ost[d]);
                end else begin
                    want = exp_q.pop_front();
                    if (ost[d] !== want) $display("FAIL b2b[%0d] item %0d: got %h want %h", d, got, ost[d], want);
                    else n_pass++;
                end
                got++;
            end
            if (v[d] === 1'b1 && ordy[d] === 1'b1) begin
                exp_q.push_back(cur_byp ? cur : ref_mix(cur, cur_enc));
                sent++;
                cur     = {$urandom, $urandom, $urandom, $urandom};
                cur_enc = 1'($urandom_range(0, 1));
                cur_byp = ($urandom_range(0, 3) == 0);
            end
        end
        n_checks++;
        if (got !== 8 || exp_q.size() != 0)
            $display("FAIL b2b[%0d] count: got %0d outputs (%0d pending) want 8", d, got, exp_q.size());
        else n_pass++;
        v[d] = 1'b0; rdy[d] = 1'b0; byp_in = 1'b0;
        @(negedge clk);
        rdy[d] = 1'b1;
        @(negedge clk);
        rdy[d] = 1'b0;
    endtask

    task automatic test_roundtrip();
        logic [127:0] pt;
        logic [127:0] ct;
        pt = {$urandom, $urandom, $urandom, $urandom};
        ct = ref_mix(pt, 1'b1);
        do_txn(1, pt, 1'b1, 1'b0, ct, 2, "rt_enc");
        do_txn(1, ost[1], 1'b0, 1'b0, pt, 2, "rt_dec");
    endtask

    initial begin
        test_reset();
        test_enc_nc1();
        test_dec_nc4_nc2();
        test_bypass();
        test_backpressure();
        test_reset_mid_run();
        for (int d = 0; d < 3; d++) test_back_to_back(d);
        test_roundtrip();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
